// File: rtl/bcd_seg_scan_pkg.sv
// Shared definitions for the two-digit BCD 7-segment scanner.
// Holds the scan state encoding, the active-low segment codes and the
// anode/blank constants used by bcd_seg_scan and seg7_decode.
package bcd_seg_scan_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;

    // Scan sequence: units digit, gap, tens digit, gap
    typedef enum logic [1:0] {
        SHOW_UND = 2'd0,
        GAP_UND  = 2'd1,
        SHOW_DEC = 2'd2,
        GAP_DEC  = 2'd3
    } scan_state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low anodes, bit order {DEC,UND}
    localparam logic [AN_W-1:0] AN_OFF = 2'b11;
    localparam logic [AN_W-1:0] AN_UND = 2'b10;
    localparam logic [AN_W-1:0] AN_DEC = 2'b01;

endpackage

// File: rtl/bcd_seg_scan_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports:
//   digit  - 4-bit BCD digit; codes 10..15 show a dash
//   seg_c  - active-low segments {g,f,e,d,c,b,a} (combinational)
module seg7_decode
    import bcd_seg_scan_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed 7-segment driver for a BCD converter.
// Latches the converter result on the rising edge of in_DONE, scans the
// units and tens digits with anode-off gaps between them, and requests a
// new conversion once per scan frame.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   in_DONE    - converter done level
//   in_UND     - BCD units digit
//   in_DEC     - BCD tens digit
//   out_INIT   - one-cycle conversion request (registered)
//   out_SEG    - active-low segments {g,f,e,d,c,b,a} (registered)
//   out_AN     - active-low anodes {DEC,UND} (registered)
//   out_VALID  - a conversion has been captured since reset
// Optional feature: define BCD_BLANK_ZERO_EN to blank a leading-zero tens digit.
module bcd_seg_scan
    import bcd_seg_scan_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd1000,
    parameter logic [7:0]  GAP_CYC  = 8'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_DONE,
    input  logic [DIGIT_W-1:0] in_UND,
    input  logic [DIGIT_W-1:0] in_DEC,
    output logic               out_INIT,
    output logic [SEG_W-1:0]   out_SEG,
    output logic [AN_W-1:0]    out_AN,
    output logic               out_VALID
);

    localparam logic [15:0] SHOW_LOAD = SCAN_DIV - 16'd1;
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC) - 16'd1;
    localparam bit          NO_GAP    = (GAP_CYC == 8'd0);
    // Last state of a frame; its final cycle is where a conversion is requested
    localparam scan_state_t LAST_ST   = NO_GAP ? SHOW_DEC : GAP_DEC;

    scan_state_t        state, state_nx;
    logic [15:0]        cnt, cnt_nx;
    logic               done_q;
    logic [DIGIT_W-1:0] und_q, dec_q, und_nx, dec_nx;
    logic               capture, valid_nx, frame_end;
    logic [DIGIT_W-1:0] digit_mux;
    logic [SEG_W-1:0]   seg_code;
    logic [SEG_W-1:0]   seg_nx;
    logic [AN_W-1:0]    an_nx;

    // Scan sequencing: shared down-counter reloads on every state change
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 16'd1;
        if (cnt == 16'd0) begin
            case (state)
                SHOW_UND: state_nx = NO_GAP ? SHOW_DEC : GAP_UND;
                GAP_UND:  state_nx = SHOW_DEC;
                SHOW_DEC: state_nx = NO_GAP ? SHOW_UND : GAP_DEC;
                GAP_DEC:  state_nx = SHOW_UND;
                default:  state_nx = SHOW_UND;
            endcase
            cnt_nx = (state_nx == SHOW_UND || state_nx == SHOW_DEC) ? SHOW_LOAD : GAP_LOAD;
        end
    end

    // Rising-edge capture; next-cycle values are bypassed into the display
    // so the new digits appear one cycle after the capturing cycle
    assign capture   = in_DONE && !done_q;
    assign und_nx    = capture ? in_UND : und_q;
    assign dec_nx    = capture ? in_DEC : dec_q;
    assign valid_nx  = out_VALID || capture;
    assign frame_end = (cnt == 16'd0) && (state == LAST_ST);
    assign digit_mux = (state_nx == SHOW_DEC) ? dec_nx : und_nx;

    seg7_decode u_seg7_decode (
        .digit (digit_mux),
        .seg_c (seg_code)
    );

    // Display selection for the upcoming cycle
    always_comb begin
        an_nx  = AN_OFF;
        seg_nx = SEG_BLANK;
        if (valid_nx) begin
            case (state_nx)
                SHOW_UND: begin
                    an_nx  = AN_UND;
                    seg_nx = seg_code;
                end
                SHOW_DEC: begin
                    an_nx  = AN_DEC;
                    seg_nx = seg_code;
`ifdef BCD_BLANK_ZERO_EN
                    if (dec_nx == 4'd0) begin
                        an_nx  = AN_OFF;
                        seg_nx = SEG_BLANK;
                    end
`endif
                end
                default: begin
                    an_nx  = AN_OFF;
                    seg_nx = SEG_BLANK;
                end
            endcase
        end
    end

    // State, capture registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SHOW_UND;
            cnt       <= SHOW_LOAD;
            done_q    <= 1'b0;
            und_q     <= '0;
            dec_q     <= '0;
            out_VALID <= 1'b0;
            out_INIT  <= 1'b0;
            out_AN    <= AN_OFF;
            out_SEG   <= SEG_BLANK;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            done_q    <= in_DONE;
            und_q     <= und_nx;
            dec_q     <= dec_nx;
            out_VALID <= valid_nx;
            // Request decided on the last frame cycle, visible the cycle after
            out_INIT  <= frame_end && !in_DONE;
            out_AN    <= an_nx;
            out_SEG   <= seg_nx;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan: two instances (with and without gap
// states) are driven in parallel and compared each cycle against a model
// that derives the display from the cycle index within a scan frame.
module tb_bcd_seg_scan;

    localparam int S0 = 8;
    localparam int G0 = 3;
    localparam int F0 = 2 * S0 + 2 * G0;
    localparam int S1 = 5;
    localparam int G1 = 0;
    localparam int F1 = 2 * S1 + 2 * G1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_DONE;
    logic [3:0] in_UND, in_DEC;
    logic       out_INIT0, out_VALID0, out_INIT1, out_VALID1;
    logic [6:0] out_SEG0, out_SEG1;
    logic [1:0] out_AN0, out_AN1;
    logic [10:0] obs0, obs1, e0, e1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: cycle index since reset, captured digits, expected requests
    int         k = 0;
    logic [3:0] m_und = 4'd0, m_dec = 4'd0;
    logic       m_valid = 1'b0, m_done_prev = 1'b0, m_init0 = 1'b0, m_init1 = 1'b0;

    always #5 clk = ~clk;

    bcd_seg_scan #(.SCAN_DIV(16'(S0)), .GAP_CYC(8'(G0))) dut0 (
        .clk(clk), .rst(rst), .in_DONE(in_DONE), .in_UND(in_UND), .in_DEC(in_DEC),
        .out_INIT(out_INIT0), .out_SEG(out_SEG0), .out_AN(out_AN0), .out_VALID(out_VALID0));

    bcd_seg_scan #(.SCAN_DIV(16'(S1)), .GAP_CYC(8'(G1))) dut1 (
        .clk(clk), .rst(rst), .in_DONE(in_DONE), .in_UND(in_UND), .in_DEC(in_DEC),
        .out_INIT(out_INIT1), .out_SEG(out_SEG1), .out_AN(out_AN1), .out_VALID(out_VALID1));

    assign obs0 = {out_VALID0, out_INIT0, out_AN0, out_SEG0};
    assign obs1 = {out_VALID1, out_INIT1, out_AN1, out_SEG1};

    always @(posedge clk) begin
        if (rst) begin
            k <= 0; m_und <= 4'd0; m_dec <= 4'd0; m_valid <= 1'b0;
            m_done_prev <= 1'b0; m_init0 <= 1'b0; m_init1 <= 1'b0;
        end else begin
            k <= k + 1;
            m_done_prev <= in_DONE;
            if (in_DONE && !m_done_prev) begin
                m_und <= in_UND; m_dec <= in_DEC; m_valid <= 1'b1;
            end
            m_init0 <= (k % F0 == F0 - 1) && !in_DONE;
            m_init1 <= (k % F1 == F1 - 1) && !in_DONE;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // Expected {VALID, INIT, AN, SEG} for cycle kk of a scanner with show s / gap g
    function automatic logic [10:0] expect_out(input int s, input int g, input int kk,
            input logic v, input logic init, input logic [3:0] u, input logic [3:0] d);
        int p;
        logic [1:0] an;
        logic [6:0] sg;
        p  = kk % (2 * s + 2 * g);
        an = 2'b11;
        sg = 7'h7F;
        if (v) begin
            if (p < s) begin
                an = 2'b10; sg = seg_of(u);
            end else if (p >= s + g && p < 2 * s + g) begin
                an = 2'b01; sg = seg_of(d);
`ifdef BCD_BLANK_ZERO_EN
                if (d == 4'd0) begin an = 2'b11; sg = 7'h7F; end
`endif
            end
        end
        return {v, init, an, sg};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        e0 = expect_out(S0, G0, k, m_valid, m_init0, m_und, m_dec);
        e1 = expect_out(S1, G1, k, m_valid, m_init1, m_und, m_dec);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_DONE = 1'b0; in_UND = 4'd0; in_DEC = 4'd0;
        tick(); tick();
        n_cmp++;
        if (obs0 !== 11'b0_0_11_1111111) begin
            n_bad++; $display("FAIL reset dut0 got=%h want=%h", obs0, 11'b0_0_11_1111111);
        end
        n_cmp++;
        if (obs1 !== 11'b0_0_11_1111111) begin
            n_bad++; $display("FAIL reset dut1 got=%h want=%h", obs1, 11'b0_0_11_1111111);
        end
        rst = 1'b0;
    endtask

    task automatic test_no_done();
        int c0 = 0, c1 = 0;
        for (int i = 0; i < 3 * F0; i++) begin
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL no_done dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL no_done dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (out_INIT0) c0++;
            if (out_INIT1) c1++;
        end
        n_cmp++;
        if (c0 !== 3) begin n_bad++; $display("FAIL init_per_frame dut0 got=%0d want=3", c0); end
        n_cmp++;
        if (c1 !== (3 * F0) / F1) begin
            n_bad++; $display("FAIL init_per_frame dut1 got=%0d want=%0d", c1, (3 * F0) / F1);
        end
    endtask

    task automatic test_capture();
        int n_und = 0, n_dec = 0, n_gap = 0;
        in_UND = 4'd7; in_DEC = 4'd4; in_DONE = 1'b1;
        for (int i = 0; i < 2 * F0 + 3; i++) begin
            if (i == 3) in_DONE = 1'b0;
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL capture dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL capture dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (i >= 3) begin
                if (out_AN0 == 2'b10 && out_SEG0 == 7'h78) n_und++;
                if (out_AN0 == 2'b01 && out_SEG0 == 7'h19) n_dec++;
                if (out_AN0 == 2'b11 && out_SEG0 == 7'h7F) n_gap++;
            end
        end
        n_cmp++;
        if (n_und != 2 * S0 || n_dec != 2 * S0 || n_gap != 4 * G0) begin
            n_bad++;
            $display("FAIL capture_durations got und=%0d dec=%0d gap=%0d want %0d/%0d/%0d",
                     n_und, n_dec, n_gap, 2 * S0, 2 * S0, 4 * G0);
        end
    endtask

    task automatic test_hold();
        int n3 = 0;
        in_UND = 4'd3; in_DEC = 4'd3; in_DONE = 1'b1;
        for (int i = 0; i < 21 + F0; i++) begin
            if (i == 10) begin in_UND = 4'd5; in_DEC = 4'd5; end
            if (i == 21) in_DONE = 1'b0;
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL hold dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL hold dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (i >= 21 && out_SEG0 == 7'h30) n3++;
        end
        n_cmp++;
        if (n3 != 2 * S0) begin n_bad++; $display("FAIL hold_keeps_3 got=%0d want=%0d", n3, 2 * S0); end
    endtask

    task automatic test_dash_zero();
        int ndash = 0;
        in_UND = 4'd12; in_DEC = 4'd0; in_DONE = 1'b1;
        for (int i = 0; i < 2 + F0; i++) begin
            if (i == 2) in_DONE = 1'b0;
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL dash_zero dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL dash_zero dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (i >= 2 && out_AN0 == 2'b10 && out_SEG0 == 7'h3F) ndash++;
        end
        n_cmp++;
        if (ndash != S0) begin n_bad++; $display("FAIL dash_count got=%0d want=%0d", ndash, S0); end
    endtask

    task automatic test_init_skip();
        in_DONE = 1'b0; in_UND = 4'd1; in_DEC = 4'd2;
        for (int i = 0; i < F0 && (k % F0) != F0 - 2; i++) begin
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL init_skip dut0 k=%0d got=%h want=%h", k, obs0, e0); end
        end
        in_DONE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) in_DONE = 1'b0;
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL init_skip dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL init_skip dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (i == 1) begin
                n_cmp++;
                if (out_INIT0 !== 1'b0) begin n_bad++; $display("FAIL init_skipped got=%b want=0", out_INIT0); end
            end
        end
        for (int i = 0; i < F0 && (k % F0) != 0; i++) begin
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL init_skip dut0 k=%0d got=%h want=%h", k, obs0, e0); end
        end
        n_cmp++;
        if (out_INIT0 !== 1'b1) begin n_bad++; $display("FAIL init_resumed got=%b want=1", out_INIT0); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < F0 && (k % F0) != S0 + G0 + 2; i++) tick();
        n_cmp++;
        if (out_AN0 !== 2'b01) begin n_bad++; $display("FAIL pre_reset_show_dec got=%b want=01", out_AN0); end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs0 !== 11'b0_0_11_1111111) begin
            n_bad++; $display("FAIL reset_mid dut0 got=%h want=%h", obs0, 11'b0_0_11_1111111);
        end
        rst = 1'b0; in_DONE = 1'b1; in_UND = 4'd8; in_DEC = 4'd9;
        for (int i = 0; i < F0 + 1; i++) begin
            if (i == 1) in_DONE = 1'b0;
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL reset_mid dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL reset_mid dut1 k=%0d got=%h want=%h", k, obs1, e1); end
            if (i == 1) begin
                n_cmp++;
                if ({out_AN0, out_SEG0} !== {2'b10, 7'h00}) begin
                    n_bad++; $display("FAIL restart_show_und got=%h want=%h", {out_AN0, out_SEG0}, {2'b10, 7'h00});
                end
            end
        end
    endtask

    task automatic test_random();
        int run = 0;
        for (int i = 0; i < 600; i++) begin
            if (run == 0) begin
                in_DONE = ~in_DONE;
                run = int'($urandom_range(1, 6));
            end
            run--;
            in_UND = 4'($urandom_range(0, 15));
            in_DEC = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            tick();
            n_cmp++;
            if (obs0 !== e0) begin n_bad++; $display("FAIL random dut0 k=%0d got=%h want=%h", k, obs0, e0); end
            n_cmp++;
            if (obs1 !== e1) begin n_bad++; $display("FAIL random dut1 k=%0d got=%h want=%h", k, obs1, e1); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_done();
        test_capture();
        test_hold();
        test_dash_zero();
        test_init_skip();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
